if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Generates the PC and issues in-order fetch requests to the instruction memory over a req/gnt/rvalid handshake.
- Pairs each returned word with its PC in a small response FIFO and presents pc/inst/valid to decode.
- Supports decode/hazard stall and redirect flush (branch/jump target), discarding stale in-flight responses.

Parameters:
ADDR_W, 32, PC and instruction address width
DATA_W, 32, instruction word width
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, maximum outstanding requests plus buffered words (credit limit); power of two, >=2

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high (RstEnable = 1'b1)
stall_i  in  1  decode cannot accept; hold head entry
flush_i  in  1  redirect request, one-cycle pulse
flush_pc_i  in  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
inst_req_o  out  1  fetch request valid
inst_addr_o  out  ADDR_W  fetch address (word aligned)
inst_gnt_i  in  1  memory accepts request this cycle (meaningful only while inst_req_o=1)
inst_rvalid_i  in  1  response valid, strictly in request order, earliest 1 cycle after gnt
inst_rdata_i  in  DATA_W  response word
pc_o  out  ADDR_W  PC of instruction presented to decode
inst_o  out  DATA_W  instruction presented to decode
valid_o  out  1  pc_o/inst_o valid
err_o  out  1  sticky: rvalid received with no outstanding request

Behaviour:
- Reset (rst=1 at edge): pc_q=RESET_PC, FIFOs empty, outst_cnt=0, drop_cnt=0, err_o=0. While rst=1: inst_req_o=0, valid_o=0, pc_o=0, inst_o=0 (NOP).
- inst_addr_o = pc_q.
- inst_req_o = !rst && !flush_i && (outst_cnt + fifo_cnt + drop_cnt < DEPTH), all registered counts.
- Request accept (req&gnt): push pc_q into address queue, pc_q += 4 (wraps mod 2^ADDR_W), outst_cnt++.
- Response (rvalid): if drop_cnt>0, discard word, drop_cnt--. Else pop address queue, push {addr, rdata} into data FIFO, outst_cnt--. If drop_cnt=0 and outst_cnt=0, ignore word and set err_o.
- Output: valid_o = data FIFO non-empty; pc_o/inst_o = head fields, driven from registered storage. When valid_o=0, pc_o=0 and inst_o=0.
- Pop: valid_o && !stall_i && !flush_i.
- Latency: grant in cycle N, rvalid in cycle N+1 gives valid_o in N+2. First request is issued in the first cycle after rst deasserts.
- Stall: head holds stable. Requests continue until the credit limit, then inst_req_o drops. No response is ever lost, because credit prevents FIFO overflow.
- Flush (priority over stall and pop):
  - data FIFO and address queue cleared;
  - drop_cnt_next = drop_cnt + outst_cnt − (rvalid this cycle ? 1 : 0);
  - outst_cnt=0;
  - pc_q = {flush_pc_i[ADDR_W-1:2], 2'b00};
  - inst_req_o=0 in the flush cycle;
  - valid_o=0 from the next cycle until the new target's first word returns.
- Simultaneous accept and response in one cycle: counts net out (outst_cnt unchanged).
- Simultaneous push and pop on the data FIFO: allowed at any occupancy, including full.
- Back-to-back flushes: the second flush overrides the first target; the drop count continues to accumulate correctly.

Decomposition:
- Shared package/header constants: RESET_PC default, ADDR_W/DATA_W (InstAddrBus/InstBus), NOP word 32'h0, RstEnable.
- One sub-module, fetch_fifo: synchronous FIFO (DEPTH, WIDTH) with push/pop/clear/full/empty/count.
- Instantiate fetch_fifo twice: address queue (ADDR_W) and data FIFO (ADDR_W+DATA_W).

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle later with rdata=addr^32'hFFFF_0000 -> req at 0x0,0x4,0x8…; valid_o first high 2 cycles after first gnt, pc_o=0x0, inst_o=0xFFFF_0000; one instruction per cycle.
- stall_i held 5 cycles while streaming -> pc_o/inst_o frozen; inst_req_o low once outst+fifo=2; resumes with no skipped or duplicated PC.
- flush_i with flush_pc_i=0x0000_0103 while 2 requests outstanding -> next req addr 0x0000_0100; both stale responses discarded; first valid_o shows pc_o=0x100.
- gnt withheld 3 cycles -> inst_addr_o stable at 0x8 with req high; pc_q advances only on gnt.
- rvalid pulse with no outstanding request -> err_o=1 sticky, FIFO unchanged, valid_o unaffected.
- pc_q=0xFFFF_FFFC granted -> next req addr 0x0000_0000 (wrap); rst mid-stream -> outputs zero next cycle, refetch from RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: bus widths, reset PC,
// NOP encoding and reset polarity.
package if_fetch_stage_pkg;

  localparam int          InstAddrBus    = 32;
  localparam int          InstBus        = 32;
  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
  localparam logic [31:0] NopInst        = 32'h0000_0000;
  localparam logic        RstEnable      = 1'b1;

endpackage

// File: rtl/if_fetch_stage_fetch_fifo.sv
// Small synchronous FIFO used for the fetch address queue and the data FIFO.
// clear empties it in one cycle; push and pop may coincide even when full.
module fetch_fifo
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign count   = cnt_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst == RstEnable || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: empty/count gate every read.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues in-order fetches under a credit limit, pairs
// returned words with their PC and presents them to decode with stall/flush.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrBus,
  parameter int                DATA_W   = InstBus,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ResetPcDefault),
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_gnt_i,
  input  logic              inst_rvalid_i,
  input  logic [DATA_W-1:0] inst_rdata_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              valid_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 2;

  logic                     rst_act;
  logic [ADDR_W-1:0]        pc_q;
  logic [CNT_W-1:0]         drop_q;
  logic                     err_q;

  logic [CNT_W-1:0]         outst_cnt;
  logic [CNT_W-1:0]         df_cnt;
  logic [SUM_W-1:0]         credit_used;
  logic                     accept;
  logic                     rsp_drop;
  logic                     rsp_take;
  logic                     rsp_err;
  logic                     aq_empty;
  logic                     aq_full;
  logic [ADDR_W-1:0]        aq_pc;
  logic                     df_empty;
  logic                     df_full;
  logic                     df_pop;
  logic [ADDR_W+DATA_W-1:0] df_head;
  logic                     unused_full;

  assign rst_act     = (rst == RstEnable);
  assign credit_used = SUM_W'(outst_cnt) + SUM_W'(df_cnt) + SUM_W'(drop_q);
  assign inst_req_o  = !rst_act && !flush_i && (credit_used < SUM_W'(DEPTH));
  assign inst_addr_o = pc_q;
  assign accept      = inst_req_o && inst_gnt_i;

  // The address queue occupancy is the outstanding-request count.
  assign rsp_drop = inst_rvalid_i && (drop_q != '0);
  assign rsp_take = inst_rvalid_i && (drop_q == '0) && !aq_empty;
  assign rsp_err  = inst_rvalid_i && (drop_q == '0) && aq_empty;

  assign valid_o = !rst_act && !df_empty;
  assign df_pop  = valid_o && !stall_i && !flush_i;
  assign pc_o    = valid_o ? df_head[ADDR_W+DATA_W-1:DATA_W] : '0;
  assign inst_o  = valid_o ? df_head[DATA_W-1:0] : DATA_W'(NopInst);
  assign err_o   = err_q;

  assign unused_full = aq_full ^ df_full;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W)
  ) u_addr_q (
    .clk   (clk),
    .rst   (rst),
    .clear (flush_i),
    .push  (accept),
    .din   (pc_q),
    .pop   (rsp_take),
    .dout  (aq_pc),
    .full  (aq_full),
    .empty (aq_empty),
    .count (outst_cnt)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_data_q (
    .clk   (clk),
    .rst   (rst),
    .clear (flush_i),
    .push  (rsp_take),
    .din   ({aq_pc, inst_rdata_i}),
    .pop   (df_pop),
    .dout  (df_head),
    .full  (df_full),
    .empty (df_empty),
    .count (df_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst_act) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (flush_i) begin
        pc_q   <= {flush_pc_i[ADDR_W-1:2], 2'b00};
        // Everything in flight becomes stale; a response landing now is already accounted for.
        drop_q <= drop_q + outst_cnt - CNT_W'(rsp_drop || rsp_take);
      end else begin
        if (accept)   pc_q   <= pc_q + ADDR_W'(4);
        if (rsp_drop) drop_q <= drop_q - CNT_W'(1);
      end
      if (rsp_err) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage with an in-order memory model of
// configurable response latency.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_gnt_i;
  logic        inst_rvalid_i;
  logic [31:0] inst_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        err_o;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;
  int          cyc;
  int          mem_lat;
  int          n_chk;
  int          n_fail;
  int          n_pop;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .inst_req_o    (inst_req_o),
    .inst_addr_o   (inst_addr_o),
    .inst_gnt_i    (inst_gnt_i),
    .inst_rvalid_i (inst_rvalid_i),
    .inst_rdata_i  (inst_rdata_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .valid_o       (valid_o),
    .err_o         (err_o)
  );

  // One clock: sample mid-cycle, update scoreboard/memory model, then drive the
  // memory response for the next cycle just after the edge.
  task automatic tick();
    logic acc;
    mem_req_t r;
    #1;
    acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      mem_q.delete();
      exp_pc = 32'h0;
    end else begin
      if (inst_req_o) begin
        n_chk++;
        if (inst_addr_o !== exp_pc) begin
          n_fail++;
          $display("FAIL req_addr: got %h expected %h", inst_addr_o, exp_pc);
        end
      end
      acc = inst_req_o && inst_gnt_i;
      if (valid_o) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_output: unexpected pc %h inst %h", pc_o, inst_o);
        end else begin
          if ({pc_o, inst_o} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL sb_output: got %h/%h expected %h/%h", pc_o, inst_o,
                     exp_q[0][63:32], exp_q[0][31:0]);
          end
          if (!stall_i && !flush_i) begin
            void'(exp_q.pop_front());
            n_pop++;
          end
        end
      end
      if (flush_i) begin
        exp_q.delete();
        exp_pc = {flush_pc_i[31:2], 2'b00};
      end else if (acc) begin
        exp_q.push_back({inst_addr_o, inst_addr_o ^ 32'hFFFF_0000});
        r.due  = cyc + mem_lat;
        r.addr = inst_addr_o;
        mem_q.push_back(r);
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    inst_rvalid_i = 1'b0;
    inst_rdata_i  = 32'h0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      inst_rvalid_i = 1'b1;
      inst_rdata_i  = r.addr ^ 32'hFFFF_0000;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if (inst_req_o !== 1'b0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req %b valid %b expected 0 0", inst_req_o, valid_o);
    end
    n_chk++;
    if (pc_o !== 32'h0 || inst_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: pc %h inst %h expected 0 0", pc_o, inst_o);
    end
    n_chk++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b expected 0", err_o);
    end
  endtask

  task automatic test_stream();
    int p0;
    rst = 1'b0;
    inst_gnt_i = 1'b1;
    #1;
    n_chk++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL first_req: req %b addr %h expected 1 00000000", inst_req_o, inst_addr_o);
    end
    tick();
    n_chk++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: valid %b expected 0", valid_o);
    end
    tick();
    n_chk++;
    if (valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'hFFFF_0000) begin
      n_fail++;
      $display("FAIL first_word: valid %b pc %h inst %h expected 1 00000000 ffff0000",
               valid_o, pc_o, inst_o);
    end
    p0 = n_pop;
    repeat (12) tick();
    n_chk++;
    if (n_pop - p0 < 6) begin
      n_fail++;
      $display("FAIL stream_rate: got %0d pops expected at least 6", n_pop - p0);
    end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    repeat (5) tick();
    n_chk++;
    if (inst_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_credit: req %b expected 0", inst_req_o);
    end
    n_chk++;
    if (valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_valid: valid %b expected 1", valid_o);
    end
    stall_i = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_gnt_wait();
    rst = 1'b1;
    inst_gnt_i = 1'b0;
    tick();
    rst = 1'b0;
    inst_gnt_i = 1'b1;
    tick();
    tick();
    inst_gnt_i = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h8) begin
        n_fail++;
        $display("FAIL gnt_wait_hold: req %b addr %h expected 1 00000008", inst_req_o, inst_addr_o);
      end
      tick();
    end
    inst_gnt_i = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_flush();
    bit found;
    inst_gnt_i = 1'b0;
    repeat (6) tick();
    mem_lat = 3;
    inst_gnt_i = 1'b1;
    tick();
    tick();
    flush_i    = 1'b1;
    flush_pc_i = 32'h0000_0103;
    #1;
    n_chk++;
    if (inst_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_req_low: req %b expected 0", inst_req_o);
    end
    tick();
    flush_i    = 1'b0;
    flush_pc_i = 32'h0;
    n_chk++;
    if (valid_o !== 1'b0 || inst_addr_o !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL flush_target: valid %b addr %h expected 0 00000100", valid_o, inst_addr_o);
    end
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_chk++;
    if (!found || pc_o !== 32'h0000_0100 || inst_o !== 32'hFFFF_0100) begin
      n_fail++;
      $display("FAIL flush_first_word: found %b pc %h inst %h expected 1 00000100 ffff0100",
               found, pc_o, inst_o);
    end
    repeat (8) tick();
    n_chk++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_err: err %b expected 0", err_o);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    mem_lat = 2;
    inst_gnt_i = 1'b1;
    repeat (4) tick();
    flush_i    = 1'b1;
    flush_pc_i = 32'h0000_0200;
    tick();
    flush_pc_i = 32'h0000_0300;
    tick();
    flush_i    = 1'b0;
    flush_pc_i = 32'h0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_chk++;
    if (!found || pc_o !== 32'h0000_0300 || inst_o !== 32'hFFFF_0300) begin
      n_fail++;
      $display("FAIL b2b_flush_word: found %b pc %h inst %h expected 1 00000300 ffff0300",
               found, pc_o, inst_o);
    end
    repeat (6) tick();
    n_chk++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_flush_err: err %b expected 0", err_o);
    end
  endtask

  task automatic test_err();
    bit found;
    mem_lat = 1;
    stall_i = 1'b1;
    inst_gnt_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (!inst_req_o && mem_q.size() == 0 && valid_o && !inst_rvalid_i) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL err_setup: idle full state not reached");
    end
    inst_gnt_i    = 1'b0;
    inst_rvalid_i = 1'b1;
    inst_rdata_i  = 32'hDEAD_BEEF;
    tick();
    n_chk++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: err %b expected 1", err_o);
    end
    n_chk++;
    if (valid_o !== 1'b1 || exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL err_fifo_intact: valid %b sb depth %0d expected 1 2", valid_o, exp_q.size());
    end
    repeat (2) tick();
    stall_i = 1'b0;
    inst_gnt_i = 1'b1;
    repeat (10) tick();
    n_chk++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err %b expected 1", err_o);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    inst_gnt_i = 1'b1;
    flush_i    = 1'b1;
    flush_pc_i = 32'hFFFF_FFFB;
    tick();
    flush_i    = 1'b0;
    flush_pc_i = 32'h0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (inst_req_o && inst_addr_o == 32'h0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wrap_addr: request at 00000000 not seen after fffffffc");
    end
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    int p0;
    inst_gnt_i = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    n_chk++;
    if (inst_req_o !== 1'b0 || valid_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: req %b valid %b pc %h inst %h expected all 0",
               inst_req_o, valid_o, pc_o, inst_o);
    end
    n_chk++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_err: err %b expected 0", err_o);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL refetch: req %b addr %h expected 1 00000000", inst_req_o, inst_addr_o);
    end
    p0 = n_pop;
    repeat (10) tick();
    n_chk++;
    if (n_pop <= p0) begin
      n_fail++;
      $display("FAIL refetch_flow: got %0d pops expected more than 0", n_pop - p0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    flush_pc_i    = 32'h0;
    inst_gnt_i    = 1'b0;
    inst_rvalid_i = 1'b0;
    inst_rdata_i  = 32'h0;
    exp_pc        = 32'h0;
    cyc           = 0;
    mem_lat       = 1;
    n_chk         = 0;
    n_fail        = 0;
    n_pop         = 0;

    test_reset();
    test_stream();
    test_stall();
    test_gnt_wait();
    test_flush();
    test_back_to_back();
    test_err();
    test_wrap();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
